// File: rtl/fp_clamp_sequencer_pkg.sv
// Shared types and helpers for the fcore clamp sequencer: FSM state encoding,
// saturator op selects and a sign-magnitude float compare.
package fcore_clamp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_U,
    WAIT_U,
    ISSUE_L,
    WAIT_L,
    RESP
  } state_t;

  localparam logic SAT_OP_UPPER = 1'b1;
  localparam logic SAT_OP_LOWER = 1'b0;

  localparam int unsigned FP_WIDTH = 32;

  // Sign-magnitude ordering; +0 and -0 compare equal, NaNs are not special-cased.
  function automatic logic fp_lt(input logic [FP_WIDTH-1:0] a,
                                 input logic [FP_WIDTH-1:0] b);
    logic [FP_WIDTH-2:0] ma;
    logic [FP_WIDTH-2:0] mb;
    ma = a[FP_WIDTH-2:0];
    mb = b[FP_WIDTH-2:0];
    if (a[FP_WIDTH-1] != b[FP_WIDTH-1]) begin
      return a[FP_WIDTH-1] && ((ma | mb) != '0);
    end else if (a[FP_WIDTH-1]) begin
      return ma > mb;
    end else begin
      return ma < mb;
    end
  endfunction

endpackage

// File: rtl/fp_clamp_sequencer_if.sv
// Stream bundle between the clamp sequencer and the shared saturator.
// The sequencer drives sat_op through master and receives sat_result through slave.
interface fp_clamp_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 4,
  parameter int unsigned DEST_WIDTH = 4
);

  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic [USER_WIDTH-1:0] user;
  logic [DEST_WIDTH-1:0] dest;

  modport master (output valid, data, user, dest);
  modport slave  (input  valid, data, user, dest);

endinterface

// File: rtl/fp_clamp_sequencer_arbiter.sv
// Round-robin arbiter for the clamp sequencer: the pointer holds the highest
// priority index and moves to one past the winner whenever a grant is taken.
module fp_sat_rr_arbiter #(
  parameter  int unsigned N_REQ = 2,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  int unsigned      sum;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    sum       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = 32'(ptr) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      cand = IDX_W'(sum);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/fp_clamp_sequencer.sv
// Shares one FP saturator between N_REQ requesters: min against the upper bound,
// then max against the lower bound. Optional bound-inversion check: FP_CLAMP_BOUNDS_CHECK_EN.
module fp_clamp_sequencer
  import fcore_clamp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter int unsigned N_REQ          = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]      req_operand,
  input  logic [N_REQ*DATA_WIDTH-1:0]      req_upper,
  input  logic [N_REQ*DATA_WIDTH-1:0]      req_lower,
  input  logic [N_REQ*REG_ADDR_WIDTH-1:0]  req_dest,
  output logic [DATA_WIDTH-1:0]            sat_operand_a,
  output logic [DATA_WIDTH-1:0]            sat_operand_b,
  fp_clamp_sequencer_if.master             sat_op,
  fp_clamp_sequencer_if.slave              sat_result,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [DATA_WIDTH-1:0]            resp_data,
  output logic [REG_ADDR_WIDTH-1:0]        resp_dest,
  output logic [$clog2(N_REQ)-1:0]         resp_id,
  output logic                             resp_error
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  state_t                    state;
  logic [REG_ADDR_WIDTH-1:0] tag;
  logic [DATA_WIDTH-1:0]     lat_lower;
  logic                      op_valid;
  logic                      op_sel;
  logic [REG_ADDR_WIDTH-1:0] op_user;
  logic [REG_ADDR_WIDTH-1:0] op_dest;
  logic                      err_q;

  logic [N_REQ-1:0]          grant;
  logic [ID_W-1:0]           grant_idx;
  logic                      advance;
  logic                      hit;
  logic                      inverted;
  logic [DATA_WIDTH-1:0]     sel_operand;
  logic [DATA_WIDTH-1:0]     sel_upper;
  logic [DATA_WIDTH-1:0]     sel_lower;
  logic [REG_ADDR_WIDTH-1:0] sel_dest;
  logic                      unused_result_dest;

  assign advance = (state == IDLE) && (|req_valid);

  fp_sat_rr_arbiter #(.N_REQ(N_REQ)) u_arbiter (
    .clock     (clock),
    .reset     (reset),
    .req       (req_valid),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign sel_operand = req_operand[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
  assign sel_upper   = req_upper[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
  assign sel_lower   = req_lower[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
  assign sel_dest    = req_dest[32'(grant_idx) * REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

`ifdef FP_CLAMP_BOUNDS_CHECK_EN
  assign inverted = fp_lt(sel_upper, sel_lower);
`else
  assign inverted = 1'b0;
`endif

  // Beats from a flushed sequence carry a stale tag and fall through here.
  assign hit = sat_result.valid && (sat_result.user == tag);

  assign sat_op.valid        = op_valid;
  assign sat_op.data         = DATA_WIDTH'(op_sel);
  assign sat_op.user         = op_user;
  assign sat_op.dest         = op_dest;
  assign resp_error          = err_q;
  assign unused_result_dest  = ^sat_result.dest;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      tag           <= '0;
      req_ready     <= '0;
      op_valid      <= 1'b0;
      op_sel        <= 1'b0;
      op_user       <= '0;
      op_dest       <= '0;
      sat_operand_a <= '0;
      sat_operand_b <= '0;
      lat_lower     <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_dest     <= '0;
      resp_id       <= '0;
      err_q         <= 1'b0;
    end else begin
      req_ready <= '0;
      op_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (advance) begin
            req_ready <= grant;
            lat_lower <= sel_lower;
            resp_dest <= sel_dest;
            resp_id   <= grant_idx;
            err_q     <= inverted;
            if (inverted) begin
              resp_data  <= sel_lower;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              op_valid      <= 1'b1;
              op_sel        <= SAT_OP_UPPER;
              op_user       <= tag;
              op_dest       <= sel_dest;
              sat_operand_a <= sel_operand;
              sat_operand_b <= sel_upper;
              state         <= ISSUE_U;
            end
          end
        end
        ISSUE_U: state <= WAIT_U;
        WAIT_U: begin
          // The intermediate result is held directly in operand_a for the lower pass.
          if (hit) begin
            op_valid      <= 1'b1;
            op_sel        <= SAT_OP_LOWER;
            op_user       <= tag + REG_ADDR_WIDTH'(1);
            sat_operand_a <= sat_result.data;
            sat_operand_b <= lat_lower;
            tag           <= tag + REG_ADDR_WIDTH'(1);
            state         <= ISSUE_L;
          end
        end
        ISSUE_L: state <= WAIT_L;
        WAIT_L: begin
          if (hit) begin
            resp_data  <= sat_result.data;
            resp_valid <= 1'b1;
            tag        <= tag + REG_ADDR_WIDTH'(1);
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_clamp_sequencer.sv
// Scoreboard bench for fp_clamp_sequencer with a behavioural 3-cycle saturator;
// the bounds-inversion expectations follow FP_CLAMP_BOUNDS_CHECK_EN.
module tb_fp_clamp_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned N  = 2;

  localparam logic [31:0] F_30_5  = 32'h41F4_0000;
  localparam logic [31:0] F_24    = 32'h41C0_0000;
  localparam logic [31:0] F_10    = 32'h4120_0000;
  localparam logic [31:0] F_4     = 32'h4080_0000;
  localparam logic [31:0] F_1_25  = 32'h3FA0_0000;
  localparam logic [31:0] F_M4    = 32'hC080_0000;
  localparam logic [31:0] F_M24   = 32'hC1C0_0000;
  localparam logic [31:0] F_M30   = 32'hC1F0_0000;

  typedef struct {
    logic [31:0] operand, upper, lower, mid, res;
    logic [3:0]  dest;
  } vec_t;
  typedef struct { logic op; logic [31:0] a, b; } op_t;
  typedef struct { logic [31:0] data; logic [3:0] dest; logic [0:0] id; logic err; } resp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_operand, req_upper, req_lower;
  logic [N*AW-1:0]   req_dest;
  logic [DW-1:0]     sat_operand_a, sat_operand_b;
  logic              resp_valid, resp_ready, resp_error;
  logic [DW-1:0]     resp_data;
  logic [AW-1:0]     resp_dest;
  logic [0:0]        resp_id;

  fp_clamp_sequencer_if #(.DATA_WIDTH(DW), .USER_WIDTH(AW), .DEST_WIDTH(AW)) sat_op_if ();
  fp_clamp_sequencer_if #(.DATA_WIDTH(DW), .USER_WIDTH(AW), .DEST_WIDTH(AW)) sat_res_if ();

  fp_clamp_sequencer #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .N_REQ(N)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_operand(req_operand), .req_upper(req_upper), .req_lower(req_lower), .req_dest(req_dest),
    .sat_operand_a(sat_operand_a), .sat_operand_b(sat_operand_b),
    .sat_op(sat_op_if), .sat_result(sat_res_if),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_dest(resp_dest), .resp_id(resp_id), .resp_error(resp_error)
  );

  always #5 clock = ~clock;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  op_t   op_q[$];
  resp_t resp_q[$];
  bit    inject = 1'b0;
  int unsigned stall_next = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] operand, upper, lower, mid, res, input logic [3:0] dest);
    vec_t v;
    v.operand = operand; v.upper = upper; v.lower = lower; v.mid = mid; v.res = res; v.dest = dest;
    return v;
  endfunction

  task automatic expect_vec(input vec_t v, input logic [0:0] id, input bit with_resp);
    op_t o;
    resp_t r;
    o.op = 1'b1; o.a = v.operand; o.b = v.upper; op_q.push_back(o);
    o.op = 1'b0; o.a = v.mid;     o.b = v.lower; op_q.push_back(o);
    if (with_resp) begin
      r.data = v.res; r.dest = v.dest; r.id = id; r.err = 1'b0;
      resp_q.push_back(r);
    end
  endtask

  task automatic send(input int i, input vec_t v);
    int unsigned t;
    @(negedge clock);
    req_valid[i] = 1'b1;
    req_operand[i*DW +: DW] = v.operand;
    req_upper[i*DW +: DW]   = v.upper;
    req_lower[i*DW +: DW]   = v.lower;
    req_dest[i*AW +: AW]    = v.dest;
    t = 0;
    do begin @(negedge clock); t++; end while (!req_ready[i] && t < 200);
    if (!req_ready[i]) check("grant_timeout", 64'(req_ready[i]), 64'd1);
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int unsigned t = 0;
    while (resp_q.size() != 0 && t < 500) begin @(negedge clock); t++; end
    if (resp_q.size() != 0) check("drain_timeout", 64'(resp_q.size()), 64'd0);
    repeat (2) @(negedge clock);
  endtask

  // Saturator model: result 3 negedges after the op is seen; optional early bogus beat.
  function automatic logic [31:0] key(input logic [31:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

  logic        pv[3];
  logic [31:0] pd[3];
  logic [3:0]  pu[3];
  initial begin
    op_t e;
    for (int k = 0; k < 3; k++) begin pv[k] = 1'b0; pd[k] = '0; pu[k] = '0; end
    sat_res_if.valid = 1'b0; sat_res_if.data = '0; sat_res_if.user = '0; sat_res_if.dest = '0;
    forever begin
      @(negedge clock);
      sat_res_if.valid = pv[0]; sat_res_if.data = pd[0]; sat_res_if.user = pu[0];
      pv[0] = pv[1]; pd[0] = pd[1]; pu[0] = pu[1];
      pv[1] = pv[2]; pd[1] = pd[2]; pu[1] = pu[2];
      pv[2] = 1'b0;
      if (reset !== 1'b1) begin
        for (int k = 0; k < 3; k++) pv[k] = 1'b0;
        sat_res_if.valid = 1'b0;
      end else if (sat_op_if.valid) begin
        if (op_q.size() == 0) begin
          check("unexpected_sat_op", 64'(sat_op_if.data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = op_q.pop_front();
          check("sat_op_sel", 64'(sat_op_if.data), 64'(e.op));
          check("sat_operand_a", 64'(sat_operand_a), 64'(e.a));
          check("sat_operand_b", 64'(sat_operand_b), 64'(e.b));
        end
        pv[2] = 1'b1; pu[2] = sat_op_if.user;
        if (sat_op_if.data[0])
          pd[2] = (key(sat_operand_a) < key(sat_operand_b)) ? sat_operand_a : sat_operand_b;
        else
          pd[2] = (key(sat_operand_a) < key(sat_operand_b)) ? sat_operand_b : sat_operand_a;
        if (inject && sat_op_if.data[0]) begin
          pv[0] = 1'b1; pd[0] = 32'h7F7F_FFFF; pu[0] = sat_op_if.user + 4'd7;
          inject = 1'b0;
        end
      end
    end
  end

  // Response monitor: applies back-pressure on request and checks hold stability.
  initial begin
    resp_t r;
    logic        prev_valid = 1'b0;
    logic [31:0] snap_data;
    logic [3:0]  snap_dest;
    logic [0:0]  snap_id;
    logic [N-1:0] prev_rr = '0;
    int unsigned hold = 0;
    resp_ready = 1'b1;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && req_ready != '0) begin
        check("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
        check("req_ready_pulse", 64'(prev_rr), 64'd0);
      end
      prev_rr = req_ready;
      if (resp_valid === 1'b1) begin
        if (!prev_valid) begin
          snap_data = resp_data; snap_dest = resp_dest; snap_id = resp_id;
          hold = stall_next; stall_next = 0;
        end else begin
          check("hold_stable", {resp_data, 27'd0, resp_dest, resp_id}, {snap_data, 27'd0, snap_dest, snap_id});
        end
        resp_ready = (hold == 0);
        if (resp_ready) begin
          if (resp_q.size() == 0) begin
            check("unexpected_resp", 64'(resp_data), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            r = resp_q.pop_front();
            check("resp_data", 64'(resp_data), 64'(r.data));
            check("resp_dest", 64'(resp_dest), 64'(r.dest));
            check("resp_id", 64'(resp_id), 64'(r.id));
            check("resp_error", 64'(resp_error), 64'(r.err));
          end
        end else begin
          check("stall_no_grant", 64'(req_ready), 64'd0);
          hold--;
        end
      end else begin
        resp_ready = 1'b1;
      end
      prev_valid = resp_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v[6];
    vec_t w;
    resp_t r;
    int unsigned t;
    reset = 1'b0;
    req_valid = '0; req_operand = '0; req_upper = '0; req_lower = '0; req_dest = '0;
    repeat (3) @(negedge clock);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_sat_valid", 64'(sat_op_if.valid), 64'd0);
    check("reset_resp", {resp_valid, resp_error, resp_data}, 64'd0);
    reset = 1'b1;

    // Single requests: 30.5 -> 24.0 on req0, then two on req1.
    w = mk(F_30_5, F_24, F_4, F_24, F_24, 4'd3);   expect_vec(w, 1'b0, 1'b1); send(0, w);
    w = mk(F_1_25, F_24, F_M24, F_1_25, F_1_25, 4'd9); expect_vec(w, 1'b1, 1'b1); send(1, w);
    w = mk(F_M30, F_M4, F_M24, F_M30, F_M24, 4'd10);   expect_vec(w, 1'b1, 1'b1); send(1, w);
    drain();

    // Both requesters busy: pointer is back at 0, so grants alternate 0,1,0,1,0,1.
    v[0] = mk(F_30_5, F_24, F_4, F_24, F_24, 4'd1);
    v[1] = mk(F_1_25, F_24, F_M24, F_1_25, F_1_25, 4'd2);
    v[2] = mk(F_M30, F_M4, F_M24, F_M30, F_M24, 4'd3);
    v[3] = mk(F_4, F_24, F_4, F_4, F_4, 4'd4);
    v[4] = mk(F_24, F_24, F_M4, F_24, F_24, 4'd5);
    v[5] = mk(F_M4, F_1_25, F_M24, F_M4, F_M4, 4'd6);
    for (int k = 0; k < 6; k++) expect_vec(v[k], 1'(k % 2), 1'b1);
    fork
      begin send(0, v[0]); send(0, v[2]); send(0, v[4]); end
      begin send(1, v[1]); send(1, v[3]); send(1, v[5]); end
    join
    drain();

    // Wrong-tag beat during WAIT_U must be dropped.
    inject = 1'b1;
    w = mk(F_10, F_24, F_4, F_10, F_10, 4'd7); expect_vec(w, 1'b0, 1'b1); send(0, w);
    drain();

    // Ten cycles of back-pressure with req1 waiting behind it.
    stall_next = 10;
    w = mk(F_1_25, F_24, F_4, F_1_25, F_4, 4'd8); expect_vec(w, 1'b0, 1'b1); send(0, w);
    w = mk(F_M24, F_24, F_M4, F_M24, F_M4, 4'd11); expect_vec(w, 1'b1, 1'b1); send(1, w);
    drain();

    // Inverted bounds: upper 4.0 below lower 24.0.
    w = mk(F_1_25, F_4, F_24, F_1_25, F_24, 4'd12);
`ifdef FP_CLAMP_BOUNDS_CHECK_EN
    r.data = F_24; r.dest = 4'd12; r.id = 1'b1; r.err = 1'b1; resp_q.push_back(r);
`else
    expect_vec(w, 1'b1, 1'b1);
`endif
    send(1, w);
    drain();

    // Reset while waiting for the lower-pass result.
    w = mk(F_30_5, F_24, F_4, F_24, F_24, 4'd13); expect_vec(w, 1'b0, 1'b0); send(0, w);
    t = 0;
    while (!(sat_op_if.valid === 1'b1 && sat_op_if.data[0] === 1'b0) && t < 50) begin
      @(negedge clock); t++;
    end
    check("reach_issue_l", 64'(sat_op_if.valid), 64'd1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_sat_op", {sat_op_if.valid, sat_op_if.user, sat_op_if.dest, sat_op_if.data}, 64'd0);
    check("rst_sat_operands", {sat_operand_a, sat_operand_b}, 64'd0);
    check("rst_resp", {resp_valid, resp_error, resp_id, resp_dest, resp_data}, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Recovery: tag restarts at 0, pointer at 0.
    w = mk(F_M30, F_24, F_M24, F_M30, F_M24, 4'd14); expect_vec(w, 1'b1, 1'b1); send(1, w);
    check("tag_after_reset", 64'(sat_op_if.user), 64'd0);
    drain();
    check("ops_consumed", 64'(op_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
